// File: rtl/fast_pkg.sv
// Shared types and widths for the FAST frame sequencer.
// Used by fast_kp_fifo and fast_frame_sequencer.
package fast_pkg;

    localparam int COORD_W = 10;                     // keypoint x/y width
    localparam int SCORE_W = 8;                      // keypoint score width
    localparam int ADDR_W  = 19;                     // pixel buffer address width
    localparam int PIX_W   = 8;                      // pixel width
    localparam int KP_W    = 2 * COORD_W + SCORE_W;  // packed keypoint, 28 bits
    localparam int TMO_W   = 12;                     // drain timeout counter, 4096 cycles

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SCORE_W-1:0] score;
    } kp_t;

endpackage

// File: rtl/fast_kp_fifo.sv
// Synchronous keypoint FIFO with full/empty flags and a flush input.
// A push into a full FIFO is taken when a pop happens in the same cycle.
// DEPTH must be a power of two and at least 2.
module fast_kp_fifo
    import fast_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = KP_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PW:0]             wr_q, rd_q;
    logic                    do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign o_empty = (wr_q == rd_q);
    assign o_full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    // Head is forced to zero when empty so stale entries never leak out
    assign o_data = o_empty ? '0 : mem_q[rd_q[PW-1:0]];

    // Pointer update; flush discards everything held
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pointed at
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/fast_frame_sequencer.sv
// Frame sequencer for a FAST keypoint detector: streams one frame of
// pixel addresses, forwards pixels to the detector with a start marker,
// and collects detected keypoints into a FIFO with a per-frame cap.
// Optional macro FAST_SEQ_TIMEOUT_EN: DRAIN gives up after 4096 cycles
// without a detector end pulse and flags o_overflow.
module fast_frame_sequencer
    import fast_pkg::*;
#(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int MAX_KP     = 500,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_req,
    output logic               o_busy,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic [PIX_W-1:0]   i_mem_data,
    output logic [PIX_W-1:0]   o_det_pixel,
    output logic               o_det_start,
    input  logic               i_det_flag,
    input  logic [COORD_W-1:0] i_det_x,
    input  logic [COORD_W-1:0] i_det_y,
    input  logic [SCORE_W-1:0] i_det_score,
    input  logic               i_det_end,
    output logic               o_kp_valid,
    input  logic               i_kp_ready,
    output logic [COORD_W-1:0] o_kp_x,
    output logic [COORD_W-1:0] o_kp_y,
    output logic [SCORE_W-1:0] o_kp_score,
    output logic [COORD_W-1:0] o_kp_count,
    output logic               o_frame_done,
    output logic               o_overflow
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [COORD_W-1:0] KP_LIMIT  = COORD_W'(MAX_KP);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          vld_pipe_q;     // [0]: data on i_mem_data, [1]: unused tap
    logic                first_q;        // address 0 data is on i_mem_data
    logic [PIX_W-1:0]    pix_q;
    logic                start_q;
    logic [COORD_W-1:0]  cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    logic                busy, frame_done, streaming, capturing, accept;
    logic                tmo_hit, tmo_exit;
    logic                fifo_full, fifo_empty, kp_pop, kp_push, kp_drop;
    logic                under_cap, room;
    logic [KP_W-1:0]     fifo_dout;
    kp_t                 kp_in, kp_head;

    assign accept = (state_q == ST_IDLE) && i_frame_req;

`ifdef FAST_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q;

    // Counts cycles spent in DRAIN; cleared whenever we are elsewhere
    always_ff @(posedge i_clk) begin
        if (i_rst || state_q != ST_DRAIN) tmo_q <= '0;
        else                              tmo_q <= tmo_q + 1'b1;
    end

    assign tmo_hit  = (tmo_q == '1);
    assign tmo_exit = (state_q == ST_DRAIN) && tmo_hit && !i_det_end;
`else
    assign tmo_hit  = 1'b0;
    assign tmo_exit = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_frame_req)            state_d = ST_STREAM;
            ST_STREAM: if (addr_q == LAST_ADDR)    state_d = ST_DRAIN;
            ST_DRAIN:  if (i_det_end || tmo_hit)   state_d = ST_DONE;
            ST_DONE:                               state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // Per-state control outputs
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        streaming  = 1'b0;
        capturing  = 1'b0;
        case (state_q)
            ST_IDLE:   ;
            ST_STREAM: begin busy = 1'b1; streaming = 1'b1; capturing = 1'b1; end
            ST_DRAIN:  begin busy = 1'b1; capturing = 1'b1; end
            ST_DONE:   begin busy = 1'b1; frame_done = 1'b1; end
            default:   ;
        endcase
    end

    // Address walks 0..LAST one per cycle and parks on LAST afterwards
    always_comb begin
        addr_d = addr_q;
        if (accept)                               addr_d = '0;
        else if (streaming && addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
    end

    // Address register
    always_ff @(posedge i_clk) begin
        if (i_rst) addr_q <= '0;
        else       addr_q <= addr_d;
    end

    // Pixel path: memory adds one cycle, pix_q adds the second
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe_q <= '0;
            first_q    <= 1'b0;
            pix_q      <= '0;
            start_q    <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], streaming};
            first_q    <= streaming && (addr_q == '0);
            pix_q      <= vld_pipe_q[0] ? i_mem_data : '0;
            start_q    <= first_q;
        end
    end

    // Keypoint admission: cap first, then FIFO space (a same-cycle pop frees a slot)
    assign kp_pop    = !fifo_empty && i_kp_ready;
    assign under_cap = (cnt_q < KP_LIMIT);
    assign room      = !fifo_full || kp_pop;
    assign kp_push   = capturing && i_det_flag && under_cap && room;
    assign kp_drop   = capturing && i_det_flag && !(under_cap && room);

    // Count and sticky overflow, both cleared when a new frame is accepted
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (kp_push)             cnt_d = cnt_q + 1'b1;
            if (kp_drop || tmo_exit) ovf_d = 1'b1;
        end
    end

    // Count / overflow registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign kp_in.x     = i_det_x;
    assign kp_in.y     = i_det_y;
    assign kp_in.score = i_det_score;

    fast_kp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KP_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (accept),
        .i_push  (kp_push),
        .i_data  (kp_in),
        .i_pop   (kp_pop),
        .o_data  (fifo_dout),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign kp_head      = kp_t'(fifo_dout);
    assign o_kp_valid   = !fifo_empty;
    assign o_kp_x       = kp_head.x;
    assign o_kp_y       = kp_head.y;
    assign o_kp_score   = kp_head.score;
    assign o_kp_count   = cnt_q;
    assign o_overflow   = ovf_q;
    assign o_busy       = busy;
    assign o_frame_done = frame_done;
    assign o_mem_addr   = addr_q;
    assign o_det_pixel  = pix_q;
    assign o_det_start  = start_q;

endmodule

// File: tb/tb_fast_frame_sequencer.sv
// Self-checking bench for fast_frame_sequencer on a small 8x4 frame.
// A behavioural model tracks frame phase, the expected pixel arrival per
// cycle and the keypoint queue; every cycle all outputs are compared.
module tb_fast_frame_sequencer;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int NPIX  = W * H;
    localparam int MAXKP = 6;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, frame_req, det_flag, det_end, kp_ready;
    logic [7:0]  mem_data, det_score;
    logic [9:0]  det_x, det_y;

    logic        o_busy, o_det_start, o_kp_valid, o_frame_done, o_overflow;
    logic [18:0] o_mem_addr;
    logic [7:0]  o_det_pixel, o_kp_score;
    logic [9:0]  o_kp_x, o_kp_y, o_kp_count;

    always #5 clk = ~clk;

    fast_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .MAX_KP(MAXKP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_req(frame_req), .o_busy(o_busy),
        .o_mem_addr(o_mem_addr), .i_mem_data(mem_data),
        .o_det_pixel(o_det_pixel), .o_det_start(o_det_start),
        .i_det_flag(det_flag), .i_det_x(det_x), .i_det_y(det_y),
        .i_det_score(det_score), .i_det_end(det_end),
        .o_kp_valid(o_kp_valid), .i_kp_ready(kp_ready),
        .o_kp_x(o_kp_x), .o_kp_y(o_kp_y), .o_kp_score(o_kp_score),
        .o_kp_count(o_kp_count), .o_frame_done(o_frame_done),
        .o_overflow(o_overflow)
    );

    // Pixel buffer: data for an address appears one cycle later
    logic [7:0] pix [NPIX];
    always @(posedge clk) mem_data <= pix[o_mem_addr[4:0]];

    // Reference model state
    int          m_phase;          // 0 idle, 1 streaming, 2 draining, 3 done
    int          m_addr, m_cnt, m_tmo, cyc;
    bit          m_ovf;
    logic [27:0] m_q[$];
    logic [7:0]  exp_pix [int];    // keyed by cycle number
    bit          exp_start [int];
    int          checks, errors, npop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: model consumes this cycle's inputs, then outputs are compared
    task automatic tick();
        int          n_phase;
        bit          pop, push;
        logic [7:0]  ep;
        bit          es;
        logic [27:0] head;
        n_phase = m_phase;
        push    = 1'b0;
        if (o_kp_valid && kp_ready) npop++;
        if (rst) begin
            n_phase = 0; m_addr = 0; m_cnt = 0; m_ovf = 0; m_tmo = 0;
            m_q.delete(); exp_pix.delete(); exp_start.delete();
        end else begin
            pop = (m_q.size() > 0) && kp_ready;
            if ((m_phase == 1 || m_phase == 2) && det_flag) begin
                if (m_cnt < MAXKP && (m_q.size() < DEPTH || pop)) begin
                    push = 1'b1;
                    m_cnt++;
                end else m_ovf = 1'b1;
            end
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back({det_x, det_y, det_score});
            case (m_phase)
                0: if (frame_req) begin
                       n_phase = 1; m_addr = 0; m_cnt = 0; m_ovf = 0; m_q.delete();
                   end
                1: begin
                       exp_pix[cyc + 2]   = pix[m_addr];
                       exp_start[cyc + 2] = (m_addr == 0);
                       if (m_addr == NPIX - 1) begin n_phase = 2; m_tmo = 0; end
                       else m_addr++;
                   end
                2: begin
                       if (det_end) n_phase = 3;
`ifdef FAST_SEQ_TIMEOUT_EN
                       else if (m_tmo == 4095) begin n_phase = 3; m_ovf = 1'b1; end
`endif
                       m_tmo++;
                   end
                default: n_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        m_phase = n_phase;
        ep   = exp_pix.exists(cyc) ? exp_pix[cyc] : 8'h00;
        es   = exp_start.exists(cyc) ? exp_start[cyc] : 1'b0;
        head = (m_q.size() > 0) ? m_q[0] : 28'h0;
        check("busy",     o_busy, m_phase != 0);
        check("done",     o_frame_done, m_phase == 3);
        check("addr",     o_mem_addr, m_addr);
        check("pixel",    o_det_pixel, ep);
        check("start",    o_det_start, es);
        check("kp_valid", o_kp_valid, m_q.size() > 0);
        check("kp_data",  {o_kp_x, o_kp_y, o_kp_score}, head);
        check("kp_count", o_kp_count, m_cnt);
        check("overflow", o_overflow, m_ovf);
    endtask

    // Accept a frame and stream all addresses with a keypoint pattern
    task automatic stream_frame(input int mode);
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            case (mode)
                0: det_flag = (i == 5 || i == 12 || i == 20);
                1: det_flag = (i >= 3 && i <= 7);
                2: det_flag = (i >= 2 && i <= 9);
                default: begin
                    det_flag = 1'($urandom_range(0, 1));
                    kp_ready = 1'($urandom_range(0, 1));
                end
            endcase
            frame_req = (i == 8);   // must be ignored while busy
            det_x     = 10'($urandom);
            det_y     = 10'($urandom);
            det_score = 8'($urandom);
            tick();
        end
        det_flag  = 1'b0;
        frame_req = 1'b0;
    endtask

    // Spend some cycles in DRAIN, then end the frame
    task automatic finish_frame(input int drain);
        for (int i = 0; i < drain; i++) tick();
        det_end = 1'b1;
        tick();
        det_end = 1'b0;
        check("done_pulse", o_frame_done, 1);
        det_flag = 1'b1;            // flag in DONE must be ignored
        tick();
        det_flag = 1'b0;
        check("done_clear", o_frame_done, 0);
        check("idle_busy",  o_busy, 0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; npop = 0;
        m_phase = 0; m_addr = 0; m_cnt = 0; m_ovf = 0; m_tmo = 0;
        foreach (pix[i]) pix[i] = 8'($urandom);
        rst = 1'b1; frame_req = 1'b0; det_flag = 1'b0; det_end = 1'b0; kp_ready = 1'b0;
        det_x = '0; det_y = '0; det_score = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy",  o_busy, 0);
        check("rst_addr",  o_mem_addr, 0);
        check("rst_valid", o_kp_valid, 0);

        // Frame 1: three keypoints, consumer always ready
        kp_ready = 1'b1;
        npop = 0;
        stream_frame(0);
        finish_frame(3);
        check("f1_count", o_kp_count, 3);
        check("f1_ovf",   o_overflow, 0);
        check("f1_pops",  npop, 3);

        // Frame 2: consumer stalled, five keypoints into a four-deep FIFO
        kp_ready = 1'b0;
        stream_frame(1);
        check("f2_count", o_kp_count, 4);
        check("f2_ovf",   o_overflow, 1);
        npop = 0;
        kp_ready = 1'b1;
        finish_frame(6);
        check("f2_pops",  npop, 4);

        // Frame 3: eight keypoints against a cap of six
        stream_frame(2);
        finish_frame(2);
        check("f3_count", o_kp_count, MAXKP);
        check("f3_ovf",   o_overflow, 1);

        // Random frames
        for (int f = 0; f < 4; f++) begin
            stream_frame(3);
            finish_frame($urandom_range(0, 5));
        end

        // Abort mid-frame at address 10 with keypoints pending
        kp_ready = 1'b0;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            det_flag = (i >= 4 && i <= 6);
            tick();
        end
        det_flag = 1'b0;
        check("pre_abort_addr", o_mem_addr, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",  o_busy, 0);
        check("abort_addr",  o_mem_addr, 0);
        check("abort_pix",   o_det_pixel, 0);
        check("abort_valid", o_kp_valid, 0);
        check("abort_count", o_kp_count, 0);
        tick();
        tick();

`ifdef FAST_SEQ_TIMEOUT_EN
        begin
            int n;
            kp_ready = 1'b1;
            stream_frame(0);
            n = 0;
            while (!o_frame_done && n < 5000) begin
                tick();
                n++;
            end
            check("tmo_cycles", n, 4096);
            check("tmo_ovf",    o_overflow, 1);
            tick();
            check("tmo_idle",   o_busy, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fast_frame_sequencer.md
FAST_FRAME_SEQUENCER -- requirements
Module: fast_frame_sequencer

Interface
REQ-001 Parameter WIDTH, default 640, pixels per line.
REQ-002 Parameter HEIGHT, default 480, lines per frame.
REQ-003 Parameter MAX_KP, default 500, keypoints accepted per frame.
REQ-004 Parameter FIFO_DEPTH, default 4, keypoint FIFO entries (power of 2).
REQ-005 Ports, clock and reset first:
 - i_clk  in  1  sole clock; rising edge.
 - i_rst  in  1  reset; synchronous, active-high.
 - i_frame_req  in  1  one-cycle frame-start request.
 - o_busy  out  1  high from accepted request until o_frame_done.
 - o_mem_addr  out  19  pixel buffer read address.
 - i_mem_data  in  8  pixel data, valid 1 cycle after address.
 - o_det_pixel  out  8  pixel to detector.
 - o_det_start  out  1  first-pixel marker to detector.
 - i_det_flag  in  1  detector keypoint valid.
 - i_det_x, i_det_y  in  10 each  keypoint coordinates.
 - i_det_score  in  8  keypoint score.
 - i_det_end  in  1  detector end-of-frame pulse.
 - o_kp_valid  out  1  keypoint available.
 - i_kp_ready  in  1  consumer accepts keypoint.
 - o_kp_x, o_kp_y  out  10 each; o_kp_score  out  8.
 - o_kp_count  out  10  keypoints accepted this frame.
 - o_frame_done  out  1  one-cycle frame-complete pulse.
 - o_overflow  out  1  sticky per frame: keypoint dropped.

Function
REQ-006 FSM states IDLE, STREAM, DRAIN, DONE; IDLE -> STREAM on i_frame_req; STREAM -> DRAIN after address WIDTH*HEIGHT-1 issued; DRAIN -> DONE on i_det_end; DONE -> IDLE unconditionally next cycle.
REQ-007 STREAM: o_mem_addr starts at 0, increments by 1 every cycle, no stalls.
REQ-008 o_det_pixel = i_mem_data registered path; pixel for address N reaches detector exactly 2 cycles after address N issued.
REQ-009 o_det_start high for exactly the cycle carrying pixel of address 0; low otherwise.
REQ-010 o_det_pixel driven 0 outside valid pixel cycles.
REQ-011 i_frame_req ignored while o_busy=1.
REQ-012 On i_frame_req accept: o_kp_count, o_overflow cleared; FIFO flushed.
REQ-013 Keypoint capture in STREAM and DRAIN: i_det_flag=1, o_kp_count<MAX_KP, FIFO not full -> push {x,y,score}, o_kp_count+1.
REQ-014 i_det_flag=1 with FIFO full or o_kp_count=MAX_KP -> keypoint dropped, o_overflow set; count unchanged.
REQ-015 FIFO valid/ready: pop when o_kp_valid & i_kp_ready; simultaneous push and pop on full FIFO permitted (no drop).
REQ-016 o_frame_done asserted exactly one cycle, in DONE; o_busy low from the following cycle.
REQ-017 i_det_flag in IDLE or DONE ignored.
REQ-018 o_mem_addr holds last value outside STREAM.

Reset
REQ-019 i_rst sampled on rising i_clk only; all outputs 0, FSM IDLE, FIFO empty, in the cycle after i_rst high.
REQ-020 i_rst mid-frame aborts immediately; no o_frame_done pulse; pending FIFO contents discarded.

Configuration
REQ-021 Macro FAST_SEQ_TIMEOUT_EN defined: DRAIN also exits to DONE after 4096 cycles without i_det_end, and o_overflow set on that exit.
REQ-022 Macro undefined: DRAIN waits indefinitely for i_det_end; no timeout counter present.

Structure
REQ-023 Package fast_pkg holds FSM state encoding, coordinate width (10), score width (8), address width (19).
REQ-024 Sub-module fast_kp_fifo: synchronous FIFO, 28-bit entries, depth FIFO_DEPTH, full/empty flags.

Verification
REQ-025 WIDTH=8, HEIGHT=4, pulse i_frame_req -> addresses 0..31 on consecutive cycles, o_det_start coincident with pixel from addr 0 two cycles later.
REQ-026 Inject 3 keypoints, i_kp_ready=1 -> 3 FIFO outputs in order, o_kp_count=3, o_overflow=0.
REQ-027 MAX_KP=2, inject 3 keypoints -> o_kp_count=2, o_overflow=1, third dropped.
REQ-028 i_kp_ready=0, inject 5 keypoints, depth 4 -> 4 held, o_overflow=1; then ready=1 -> 4 popped in order.
REQ-029 i_det_end pulse in DRAIN -> o_frame_done one cycle later for one cycle; i_frame_req during STREAM ignored.
REQ-030 i_rst at address 10 -> next cycle all outputs 0, state IDLE; with FAST_SEQ_TIMEOUT_EN and no i_det_end -> o_frame_done 4096 cycles into DRAIN, o_overflow=1.
